// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - RV32I field packer and sequential instruction-memory writer
// Optional IMM_CHECK_EN: per-format immediate range check with sticky imm_err output.
module instr_encoder_writer #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words,
`ifdef IMM_CHECK_EN
    output logic              imm_err,
`endif
    output logic              bad_fmt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] enc;
    logic [6:0]  f7;
    logic        imm_ok;
    logic        last_pending;
    logic        accept_w;
    logic        xfer;
    logic        start_ok;

    assign f7           = {1'b0, in_funct7b5, 5'b0};
    assign accept_w     = mem_we & mem_ready;
    assign last_pending = mem_we & (mem_addr == ADDR_W'(DEPTH - 1));
    assign xfer         = in_valid & in_ready;
    assign start_ok     = start & ((state == S_IDLE) | (state == S_DONE));

    always_comb begin
        enc = 32'h0000_0013;
        case (in_fmt)
            3'b000: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            3'b001: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            3'b010: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_op};
            3'b011: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            3'b100: enc = {in_imm[31:12], in_rd, in_op};
            3'b101: enc = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
            3'b110: enc = {f7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            default: enc = 32'h0000_0013;
        endcase
    end

`ifdef IMM_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(in_imm);

    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            3'b000, 3'b001: imm_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            3'b010: imm_ok = (simm >= -32'sd4096) && (simm <= 32'sd4095) && !in_imm[0];
            3'b011: imm_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048575) && !in_imm[0];
            3'b101: imm_ok = (simm >= 32'sd0) && (simm <= 32'sd31);
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (accept_w && mem_addr == ADDR_W'(DEPTH - 1)) state_nxt = S_DONE;
                else if (stop)                                  state_nxt = S_DRAIN;
            end
            S_DRAIN: if (!mem_we || mem_ready) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_RUN) | (state == S_DRAIN);
        done     = (state == S_DONE);
        in_ready = (state == S_RUN) & ~stop & (~mem_we | mem_ready) & ~last_pending;
    end

    // mem_addr always names the pending write; a same-cycle transfer lands on the incremented address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            words     <= '0;
            bad_fmt   <= 1'b0;
`ifdef IMM_CHECK_EN
            imm_err   <= 1'b0;
`endif
        end else if (start_ok) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            words     <= '0;
            bad_fmt   <= 1'b0;
`ifdef IMM_CHECK_EN
            imm_err   <= 1'b0;
`endif
        end else begin
            if (accept_w) begin
                mem_addr <= mem_addr + 1'b1;
                words    <= words + 1'b1;
            end
            if (xfer && imm_ok) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc;
            end else if (accept_w) begin
                mem_we <= 1'b0;
            end
            if (xfer && in_fmt == 3'b111) bad_fmt <= 1'b1;
`ifdef IMM_CHECK_EN
            if (xfer && !imm_ok) imm_err <= 1'b1;
`endif
        end
    end

endmodule
